// File: rtl/sl_bus_arbiter_pkg.sv
// Shared types and helpers for the slave-bus round-robin arbiter.
package sl_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    SLARB_IDLE  = 2'd0,
    SLARB_GRANT = 2'd1,
    SLARB_TURN  = 2'd2
  } slarb_state_e;

  localparam int HOLD_W = 16;
  localparam int TURN_W = 4;
  localparam int TCNT_W = 8;

  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (v == {TCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sl_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate so last_owner+1 sits at bit 0,
// take the lowest set bit, then rotate the index back.
module sl_bus_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic               pick_valid_o,
  output logic [IDX_W-1:0]   pick_idx_o,
  output logic [NUM_REQ-1:0] pick_onehot_o
);

  int                 start;
  int                 pos;
  int                 idx;
  logic [NUM_REQ-1:0] rot;

  always_comb begin
    start = (int'(last_owner_i) + 1) % NUM_REQ;
    rot   = '0;
    for (int i = 0; i < NUM_REQ; i++) rot[i] = eligible_i[(i + start) % NUM_REQ];
    pos = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) pos = i;
    idx           = (pos + start) % NUM_REQ;
    pick_valid_o  = |eligible_i;
    pick_idx_o    = IDX_W'(idx);
    pick_onehot_o = pick_valid_o ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/sl_bus_arbiter.sv
// Round-robin owner arbiter for the shared slave output bus: hold-until-release
// grants, watchdog revocation with per-master lockout, and a turnaround gap.
module sl_bus_arbiter
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TURNAROUND     = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               release_pls,
  output logic               timeout_pls,
  output logic [7:0]         timeout_cnt
);

  localparam bit                WD_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND == 0 ? 0 : TURNAROUND - 1);
  localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_REQ - 1);

  slarb_state_e        state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  lockout_q, lockout_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic                gv_q, gv_d;
  logic                rel_q, rel_d;
  logic                to_q, to_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TURN_W-1:0]   turn_q, turn_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                owner_req;
  logic                expire;

  sl_bus_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eligible_i    (req & ~lockout_q),
    .last_owner_i  (last_q),
    .pick_valid_o  (pick_valid),
    .pick_idx_o    (pick_idx),
    .pick_onehot_o (pick_onehot)
  );

  assign owner_req = req[idx_q];
  assign expire    = WD_EN && (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    gv_d      = gv_q;
    rel_d     = 1'b0;
    to_d      = 1'b0;
    tcnt_d    = tcnt_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    // A locked-out master is forgiven as soon as it lets go of req.
    lockout_d = lockout_q & req;
    case (state_q)
      SLARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          last_d  = pick_idx;
          gv_d    = 1'b1;
          hold_d  = '0;
          state_d = SLARB_GRANT;
        end
      end
      SLARB_GRANT: begin
        if (!owner_req || expire) begin
          grant_d = '0;
          idx_d   = '0;
          gv_d    = 1'b0;
          rel_d   = 1'b1;
          turn_d  = '0;
          state_d = (TURNAROUND == 0) ? SLARB_IDLE : SLARB_TURN;
          // Owner drop wins over a coincident expiry.
          if (owner_req) begin
            to_d      = 1'b1;
            tcnt_d    = sat_inc(tcnt_q);
            lockout_d = lockout_d | grant_q;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      SLARB_TURN: begin
        if (turn_q == TURN_LAST) state_d = SLARB_IDLE;
        else                     turn_d  = turn_q + 1'b1;
      end
      default: state_d = SLARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SLARB_IDLE;
      grant_q   <= '0;
      lockout_q <= '0;
      idx_q     <= '0;
      last_q    <= LAST_RST;
      gv_q      <= 1'b0;
      rel_q     <= 1'b0;
      to_q      <= 1'b0;
      tcnt_q    <= '0;
      hold_q    <= '0;
      turn_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      lockout_q <= lockout_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      gv_q      <= gv_d;
      rel_q     <= rel_d;
      to_q      <= to_d;
      tcnt_q    <= tcnt_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = gv_q;
  assign grant_idx   = idx_q;
  assign release_pls = rel_q;
  assign timeout_pls = to_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_sl_bus_arbiter.sv
// Directed bench: instance a uses the default watchdog, instance b a short one.
module tb_sl_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] g_a, g_b;
  logic       gv_a, gv_b, rel_a, rel_b, to_a, to_b;
  logic [1:0] idx_a, idx_b;
  logic [7:0] tc_a, tc_b;
  int         ncmp = 0;
  int         nmis = 0;

  always #5 clk = ~clk;

  sl_bus_arbiter #(.NUM_REQ(4), .IDX_W(2), .TURNAROUND(1), .TIMEOUT_CYCLES(4096)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .grant(g_a), .grant_valid(gv_a),
    .grant_idx(idx_a), .release_pls(rel_a), .timeout_pls(to_a), .timeout_cnt(tc_a));

  sl_bus_arbiter #(.NUM_REQ(4), .IDX_W(2), .TURNAROUND(1), .TIMEOUT_CYCLES(8)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .grant(g_b), .grant_valid(gv_b),
    .grant_idx(idx_b), .release_pls(rel_b), .timeout_pls(to_b), .timeout_cnt(tc_b));

  // Structural invariants on both instances every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      ncmp++;
      if ($countones(g_a) > 1 || gv_a !== (|g_a) || (g_a == 0 && idx_a != 0) ||
          (g_a != 0 && g_a[idx_a] !== 1'b1)) begin
        nmis++;
        $display("FAIL inv_a: grant=%b valid=%b idx=%0d want one-hot-or-zero, consistent", g_a, gv_a, idx_a);
      end
      ncmp++;
      if ($countones(g_b) > 1 || gv_b !== (|g_b) || (g_b == 0 && idx_b != 0) ||
          (g_b != 0 && g_b[idx_b] !== 1'b1)) begin
        nmis++;
        $display("FAIL inv_b: grant=%b valid=%b idx=%0d want one-hot-or-zero, consistent", g_b, gv_b, idx_b);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; req_a = '0; req_b = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(); tick();
    ncmp++; if (g_a !== 4'b0 || gv_a !== 1'b0 || idx_a !== 2'd0) begin
      nmis++; $display("FAIL reset_grant: grant=%b valid=%b idx=%0d want 0/0/0", g_a, gv_a, idx_a); end
    ncmp++; if (rel_a !== 1'b0 || to_a !== 1'b0 || tc_a !== 8'd0 || tc_b !== 8'd0) begin
      nmis++; $display("FAIL reset_misc: rel=%b to=%b cnt=%0d/%0d want 0", rel_a, to_a, tc_a, tc_b); end
    reset = 1'b0;
  endtask

  task automatic test_rr_all;
    logic [3:0] expg;
    apply_reset();
    req_a = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      expg = 4'b0001 << o;
      ncmp++; if (g_a !== expg || idx_a !== 2'(o)) begin
        nmis++; $display("FAIL rr_grant k=%0d: grant=%b idx=%0d want %b idx %0d", k, g_a, idx_a, expg, o); end
      req_a[o] = 1'b0; tick();
      ncmp++; if (g_a !== 4'b0 || rel_a !== 1'b1) begin
        nmis++; $display("FAIL rr_release k=%0d: grant=%b rel=%b want 0000/1", k, g_a, rel_a); end
      req_a[o] = 1'b1; tick();
      ncmp++; if (g_a !== 4'b0 || rel_a !== 1'b0) begin
        nmis++; $display("FAIL rr_turn k=%0d: grant=%b rel=%b want 0000/0", k, g_a, rel_a); end
      tick();
    end
    req_a = '0; tick(); tick(); tick();
  endtask

  task automatic test_single;
    int hold_bad = 0;
    int rels = 0;
    apply_reset();
    req_a = 4'b0100;
    tick();
    ncmp++; if (g_a !== 4'b0100 || idx_a !== 2'd2 || gv_a !== 1'b1) begin
      nmis++; $display("FAIL single_grant: grant=%b idx=%0d valid=%b want 0100/2/1", g_a, idx_a, gv_a); end
    repeat (9) begin
      tick();
      if (g_a !== 4'b0100) hold_bad++;
      if (rel_a === 1'b1) rels++;
    end
    ncmp++; if (hold_bad != 0) begin
      nmis++; $display("FAIL single_hold: %0d cycles lost grant, want 0", hold_bad); end
    req_a = '0; tick();
    ncmp++; if (g_a !== 4'b0 || rel_a !== 1'b1 || idx_a !== 2'd0) begin
      nmis++; $display("FAIL single_release: grant=%b rel=%b idx=%0d want 0000/1/0", g_a, rel_a, idx_a); end
    rels += int'(rel_a);
    repeat (3) begin tick(); rels += int'(rel_a); end
    ncmp++; if (rels != 1) begin
      nmis++; $display("FAIL single_rel_count: %0d pulses want 1", rels); end
  endtask

  task automatic test_wrap;
    apply_reset();
    req_a = 4'b1000; tick();
    ncmp++; if (g_a !== 4'b1000 || idx_a !== 2'd3) begin
      nmis++; $display("FAIL wrap_own3: grant=%b idx=%0d want 1000/3", g_a, idx_a); end
    req_a = 4'b1100; tick();
    req_a = 4'b0101; tick();
    ncmp++; if (g_a !== 4'b0 || rel_a !== 1'b1) begin
      nmis++; $display("FAIL wrap_release: grant=%b rel=%b want 0000/1", g_a, rel_a); end
    tick();
    ncmp++; if (g_a !== 4'b0) begin
      nmis++; $display("FAIL wrap_turn: grant=%b want 0000", g_a); end
    tick();
    ncmp++; if (g_a !== 4'b0001 || idx_a !== 2'd0) begin
      nmis++; $display("FAIL wrap_next: grant=%b idx=%0d want 0001/0", g_a, idx_a); end
    req_a = '0; tick(); tick(); tick();
  endtask

  task automatic test_watchdog;
    int  hi = 0;
    int  leaks = 0;
    bit  done = 1'b0;
    req_b = 4'b0010;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (g_b === 4'b0010) hi++;
      else if (hi != 0) done = 1'b1;
    end
    ncmp++; if (!done || hi != 8) begin
      nmis++; $display("FAIL wd_hold: grant high %0d cycles (ended=%0d) want 8", hi, done); end
    ncmp++; if (rel_b !== 1'b1 || to_b !== 1'b1 || tc_b !== 8'd1) begin
      nmis++; $display("FAIL wd_pulse: rel=%b to=%b cnt=%0d want 1/1/1", rel_b, to_b, tc_b); end
    req_b = 4'b0110; tick();
    ncmp++; if (g_b !== 4'b0) begin
      nmis++; $display("FAIL wd_turn: grant=%b want 0000", g_b); end
    tick();
    ncmp++; if (g_b !== 4'b0100 || idx_b !== 2'd2) begin
      nmis++; $display("FAIL wd_other: grant=%b idx=%0d want 0100/2", g_b, idx_b); end
    req_b = 4'b0010;
    repeat (5) begin tick(); if (g_b !== 4'b0) leaks++; end
    ncmp++; if (leaks != 0) begin
      nmis++; $display("FAIL wd_lockout: %0d cycles granted while locked, want 0", leaks); end
    req_b = 4'b0000; tick();
    req_b = 4'b0010; tick();
    ncmp++; if (g_b !== 4'b0010 || idx_b !== 2'd1 || tc_b !== 8'd1) begin
      nmis++; $display("FAIL wd_regrant: grant=%b idx=%0d cnt=%0d want 0010/1/1", g_b, idx_b, tc_b); end
    req_b = '0; tick(); tick(); tick();
  endtask

  task automatic test_simul;
    req_b = 4'b0001; tick();
    ncmp++; if (g_b !== 4'b0001) begin
      nmis++; $display("FAIL simul_grant: grant=%b want 0001", g_b); end
    repeat (7) tick();
    ncmp++; if (g_b !== 4'b0001 || to_b !== 1'b0) begin
      nmis++; $display("FAIL simul_last: grant=%b to=%b want 0001/0", g_b, to_b); end
    req_b = '0; tick();
    ncmp++; if (g_b !== 4'b0 || rel_b !== 1'b1 || to_b !== 1'b0 || tc_b !== 8'd1) begin
      nmis++; $display("FAIL simul_drop: grant=%b rel=%b to=%b cnt=%0d want 0000/1/0/1", g_b, rel_b, to_b, tc_b); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid;
    req_a = 4'b0010; tick();
    ncmp++; if (g_a !== 4'b0010) begin
      nmis++; $display("FAIL rstmid_pre: grant=%b want 0010", g_a); end
    reset = 1'b1; tick();
    ncmp++; if (g_a !== 4'b0 || idx_a !== 2'd0 || gv_a !== 1'b0 || rel_a !== 1'b0) begin
      nmis++; $display("FAIL rstmid_drop: grant=%b idx=%0d valid=%b rel=%b want 0000/0/0/0", g_a, idx_a, gv_a, rel_a); end
    ncmp++; if (tc_a !== 8'd0 || tc_b !== 8'd0) begin
      nmis++; $display("FAIL rstmid_cnt: cnt a=%0d b=%0d want 0/0", tc_a, tc_b); end
    reset = 1'b0; req_a = '0; tick();
    ncmp++; if (rel_a !== 1'b0 || g_a !== 4'b0) begin
      nmis++; $display("FAIL rstmid_after: rel=%b grant=%b want 0/0000", rel_a, g_a); end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_single();
    test_wrap();
    test_watchdog();
    test_simul();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
